// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush and data-memory freeze with timeout.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_UsesRs2,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rd,
  input  logic       EX_BranchTaken,
  input  logic       EX_MEM_MemRead,
  input  logic       EX_MEM_MemWrite,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Write,
  output logic       EX_MEM_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       MEM_WB_Bubble,
  output logic       PCSrc_Branch,
  output logic       timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] mem_wait_cycles
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;

  logic mem_stall;
  logic load_use;
  logic branch_sel;
  logic load_use_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Hazard detection; the interlock never fires for x0 since it is hardwired zero.
  assign mem_stall = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;
  assign load_use  = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
                     ((ID_EX_Rd == IF_ID_Rs1) |
                      (IF_ID_UsesRs2 & (ID_EX_Rd == IF_ID_Rs2)));

  assign branch_sel   = ~mem_stall & EX_BranchTaken;
  assign load_use_sel = ~mem_stall & ~EX_BranchTaken & load_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:      if (mem_stall)  next_state = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) next_state = RUN;
      default:                  next_state = RUN;
    endcase
  end

  // Freeze takes precedence; a branch kills the dependent instruction, so load-use is moot.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    PCSrc_Branch  = 1'b0;
    if (reset) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (mem_stall) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (branch_sel) begin
      PCSrc_Branch  = 1'b1;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
    end else if (load_use_sel) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Flush   = 1'b1;
    end
  end

  // Counter restarts from zero on entry and counts each further cycle spent waiting.
  always_comb begin
    wait_cnt_next = 8'd0;
    if (next_state == MEM_WAIT && state == MEM_WAIT)
      wait_cnt_next = sat_inc(wait_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (next_state == MEM_WAIT && wait_cnt_next == 8'hFF)
        timeout_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles    <= 32'd0;
      flush_events    <= 32'd0;
      mem_wait_cycles <= 32'd0;
    end else begin
      stall_cycles    <= stall_cycles + 32'(load_use_sel);
      flush_events    <= flush_events + 32'(branch_sel);
      mem_wait_cycles <= mem_wait_cycles + 32'(mem_stall);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; expected output vectors are hand-derived constants.
`timescale 1ns/1ps
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       IF_ID_UsesRs2, ID_EX_MemRead, EX_BranchTaken;
  logic       EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
  logic       PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic       IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, PCSrc_Branch, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // {PCWrite,IF_ID_Write,ID_EX_Write,EX_MEM_Write,IF_ID_Flush,ID_EX_Flush,MEM_WB_Bubble,PCSrc_Branch}
  localparam logic [7:0] V_NORMAL = 8'b1111_0000;
  localparam logic [7:0] V_MEMSTL = 8'b0000_0010;
  localparam logic [7:0] V_BRANCH = 8'b1111_1101;
  localparam logic [7:0] V_LDUSE  = 8'b0011_0100;
  localparam logic [7:0] V_RESET  = 8'b0000_1110;

  logic [7:0] ctl;
  assign ctl = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, PCSrc_Branch};

  hazard_controller dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .EX_BranchTaken(EX_BranchTaken),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MEM_WB_Bubble(MEM_WB_Bubble), .PCSrc_Branch(PCSrc_Branch),
    .timeout_err(timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events),
    .mem_wait_cycles(mem_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0; IF_ID_UsesRs2 = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_Rd = 5'd0; EX_BranchTaken = 1'b0;
    EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic ld_use(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic uses2);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = rd;
    IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2; IF_ID_UsesRs2 = uses2;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check_eq("reset_ctl", 32'(ctl), 32'(V_RESET));
    check_eq("reset_timeout", 32'(timeout_err), 32'd0);
    check_eq("reset_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    cyc(); reset = 1'b0;
    @(negedge clk) check_eq("post_reset_normal", 32'(ctl), 32'(V_NORMAL));

    // lw x5 in EX, add x6,x5,x7 in ID
    cyc(); ld_use(5'd5, 5'd5, 5'd7, 1'b1);
    @(negedge clk) check_eq("lu_bubble", 32'(ctl), 32'(V_LDUSE));
    cyc(); idle(); IF_ID_Rs1 = 5'd5; IF_ID_Rs2 = 5'd7; IF_ID_UsesRs2 = 1'b1;
    @(negedge clk) check_eq("lu_after", 32'(ctl), 32'(V_NORMAL));

    // Load in MEM, memory slow for three cycles
    cyc(); idle(); EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk) check_eq($sformatf("mem_stall_c%0d", i), 32'(ctl), 32'(V_MEMSTL));
      cyc();
    end
    dmem_ready = 1'b1;
    @(negedge clk) check_eq("mem_release_normal", 32'(ctl), 32'(V_NORMAL));
    cyc(); idle();
    check_eq("mem_release_wait_cnt", 32'(dut.wait_cnt), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("perf_stall_cycles", stall_cycles, 32'd1);
    check_eq("perf_mem_wait_cycles", mem_wait_cycles, 32'd3);
    check_eq("perf_flush_events", flush_events, 32'd0);
`endif

    // x0 destination never interlocks
    ld_use(5'd0, 5'd0, 5'd0, 1'b1);
    @(negedge clk) check_eq("lu_x0", 32'(ctl), 32'(V_NORMAL));
    cyc(); ld_use(5'd5, 5'd1, 5'd5, 1'b1);
    @(negedge clk) check_eq("lu_rs2_sw", 32'(ctl), 32'(V_LDUSE));
    cyc(); ld_use(5'd5, 5'd1, 5'd5, 1'b0);
    @(negedge clk) check_eq("lu_rs2_unused", 32'(ctl), 32'(V_NORMAL));

    // Branch beats load-use
    cyc(); ld_use(5'd9, 5'd9, 5'd0, 1'b0); EX_BranchTaken = 1'b1;
    @(negedge clk) check_eq("branch_over_lu", 32'(ctl), 32'(V_BRANCH));

    // Ready in the same cycle as the request: no stall, no state change
    cyc(); idle(); EX_MEM_MemWrite = 1'b1; dmem_ready = 1'b1;
    @(negedge clk) check_eq("mem_ready_same", 32'(ctl), 32'(V_NORMAL));
    cyc(); idle();
    check_eq("mem_ready_same_cnt", 32'(dut.wait_cnt), 32'd0);
    @(negedge clk) check_eq("mem_ready_same_next", 32'(ctl), 32'(V_NORMAL));

    // Branch and load-use held in frozen stages are ignored, branch honoured on release
    cyc(); idle(); EX_MEM_MemWrite = 1'b1; dmem_ready = 1'b0;
    EX_BranchTaken = 1'b1; ld_use(5'd3, 5'd3, 5'd0, 1'b0);
    @(negedge clk) check_eq("stall_hides_branch", 32'(ctl), 32'(V_MEMSTL));
    cyc();
    @(negedge clk) check_eq("stall_hides_branch2", 32'(ctl), 32'(V_MEMSTL));
    cyc(); dmem_ready = 1'b1;
    @(negedge clk) check_eq("branch_after_release", 32'(ctl), 32'(V_BRANCH));

    // Timeout: wait_cnt hits 255 after the 255th MEM_WAIT cycle (stall cycle 256)
    cyc(); idle(); EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      @(negedge clk);
      if (s == 256) check_eq("timeout_before", 32'(timeout_err), 32'd0);
      if (s == 257) check_eq("timeout_set", 32'(timeout_err), 32'd1);
      if (s == 300) begin
        check_eq("timeout_still_stall", 32'(ctl), 32'(V_MEMSTL));
        check_eq("wait_cnt_saturated", 32'(dut.wait_cnt), 32'd255);
      end
      cyc();
    end
    dmem_ready = 1'b1;
    @(negedge clk) check_eq("timeout_release_ctl", 32'(ctl), 32'(V_NORMAL));
    cyc(); idle(); cyc();
    check_eq("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a memory wait
    EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    #1;
    check_eq("midwait_reset_ctl", 32'(ctl), 32'(V_RESET));
    check_eq("midwait_reset_cnt", 32'(dut.wait_cnt), 32'd0);
    check_eq("midwait_reset_timeout", 32'(timeout_err), 32'd0);
    cyc(); idle(); reset = 1'b0;
    @(negedge clk) check_eq("midwait_post_normal", 32'(ctl), 32'(V_NORMAL));
    cyc(); ld_use(5'd12, 5'd4, 5'd12, 1'b1);
    @(negedge clk) check_eq("midwait_post_lu", 32'(ctl), 32'(V_LDUSE));
`ifdef HAZARD_PERF_CNT_EN
    check_eq("perf_after_reset", mem_wait_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: IF_ID_Rs1, IF_ID_Rs2  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL: IF_ID_UsesRs2  input  1  ID instruction reads Rs2 (R/S/B-type).
REQ-005 SHALL: ID_EX_MemRead  input  1  EX instruction is a load; ID_EX_Rd  input  5  its destination.
REQ-006 SHALL: EX_BranchTaken  input  1  branch/jump in EX resolved taken.
REQ-007 SHALL: EX_MEM_MemRead, EX_MEM_MemWrite  input  1 each  MEM-stage access request; dmem_ready  input  1  data memory completes access this cycle.
REQ-008 SHALL: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  output  1 each  stage register enables.
REQ-009 SHALL: IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble  output  1 each  insert NOP into that register.
REQ-010 SHALL: PCSrc_Branch  output  1  PC loads branch target; timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-011 SHALL: FSM states RUN and MEM_WAIT; 8-bit wait counter wait_cnt.
REQ-012 SHALL: mem_stall = (EX_MEM_MemRead|EX_MEM_MemWrite) & ~dmem_ready, evaluated combinationally in both states.
REQ-013 SHALL: load_use = ID_EX_MemRead & ID_EX_Rd!=0 & (ID_EX_Rd==IF_ID_Rs1 | (IF_ID_UsesRs2 & ID_EX_Rd==IF_ID_Rs2)).
REQ-014 SHALL: priority mem_stall > EX_BranchTaken > load_use > normal; outputs combinational from state and inputs, same cycle.
REQ-015 SHALL: normal: all *_Write=1, all flush/bubble=0, PCSrc_Branch=0.
REQ-016 SHALL: mem_stall: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write=0; MEM_WB_Bubble=1; PCSrc_Branch=0; branch and load_use ignored.
REQ-017 SHALL: branch (no mem_stall): PCSrc_Branch=1, IF_ID_Flush=1, ID_EX_Flush=1, all *_Write=1; load_use suppressed.
REQ-018 SHALL: load_use (no mem_stall, no branch): PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; EX_MEM_Write=1; exactly one bubble per load-use pair.
REQ-019 SHALL: RUN->MEM_WAIT when mem_stall; MEM_WAIT->RUN on first cycle mem_stall=0 (freeze released that same cycle).
REQ-020 SHALL: wait_cnt clears on entry to MEM_WAIT and in RUN, increments each MEM_WAIT cycle, saturates at 255.
REQ-021 SHALL: timeout_err set when wait_cnt reaches 255 while in MEM_WAIT; remains 1 until reset; pipeline continues to stall.
REQ-022 SHALL: branch held in frozen EX during MEM_WAIT is honoured in the first cycle after release.
REQ-023 SHALL: mem_stall with dmem_ready=1 in the same cycle as the request causes no stall and no state change.

Reset
REQ-024 SHALL: while reset=1: state=RUN, wait_cnt=0, timeout_err=0, PCWrite/IF_ID_Write/ID_EX_Write/EX_MEM_Write=0, IF_ID_Flush=ID_EX_Flush=MEM_WB_Bubble=1, PCSrc_Branch=0.
REQ-025 SHALL: reset asserted mid-MEM_WAIT returns to RUN immediately; first post-reset edge behaves as normal per REQ-015.

Configuration
REQ-026 SHALL: macro HAZARD_PERF_CNT_EN defined adds outputs stall_cycles, flush_events, mem_wait_cycles (32-bit each, wrapping, reset 0): +1 per load_use bubble cycle, per branch flush cycle, per mem_stall cycle respectively.
REQ-027 SHALL: without HAZARD_PERF_CNT_EN the ports and counters are absent; all other behaviour identical.

Verification
REQ-028 SHALL: lw x5 in EX, add x6,x5,x7 in ID -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle normal.
REQ-029 SHALL: load to x0 with ID reading x0 -> no stall; load x5 with ID sw using x5 only as Rs2 and UsesRs2=1 -> stall.
REQ-030 SHALL: EX_BranchTaken=1 and load_use=1 same cycle -> PCSrc_Branch=1, IF_ID_Flush=ID_EX_Flush=1, PCWrite=1.
REQ-031 SHALL: EX_MEM_MemRead=1, dmem_ready low 3 cycles -> 3 cycles all *_Write=0, MEM_WB_Bubble=1; 4th cycle normal, wait_cnt=0.
REQ-032 SHALL: dmem_ready held low 300 cycles -> timeout_err=1 from 256th wait cycle; stays 1 after release until reset.
REQ-033 SHALL: with HAZARD_PERF_CNT_EN, scenarios REQ-028 then REQ-031 -> stall_cycles=1, mem_wait_cycles=3, flush_events=0.
